// File: rtl/pid_pkg.sv
// Shared widths, constants and state encoding for the PID controller output path.
package pid_pkg;

  localparam int unsigned IN_W_DEF    = 16;
  localparam int unsigned PWM_W_DEF   = 8;
  localparam int unsigned PRESC_W_DEF = 8;
  localparam int unsigned DT_W_DEF    = 4;

  // Largest duty the driver can apply; pid_controller anti-windup clamps against it.
  localparam int unsigned DUTY_MAX = (1 << PWM_W_DEF) - 1;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_LO_ON    = 3'd1,
    ST_DT_TO_HI = 3'd2,
    ST_HI_ON    = 3'd3,
    ST_DT_TO_LO = 3'd4
  } pwm_state_e;

endpackage

// File: rtl/pid_pwm_driver_deadtime.sv
// Complementary gate-drive generator: turns the raw PWM demand into a
// high/low-side pair separated by a programmable dead gap.
module pwm_deadtime_gen
  import pid_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            raw,
  input  logic [DT_W-1:0] dead_time,
  output logic            pwm_hi,
  output logic            pwm_lo
);

  pwm_state_e      state_q;
  pwm_state_e      state_d;
  logic [DT_W-1:0] dt_q;
  logic [DT_W-1:0] dt_d;

  // State, dead counter and gate drives; drives follow the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      dt_q    <= '0;
      pwm_hi  <= 1'b0;
      pwm_lo  <= 1'b0;
    end else begin
      state_q <= state_d;
      dt_q    <= dt_d;
      pwm_hi  <= (state_d == ST_HI_ON);
      pwm_lo  <= (state_d == ST_LO_ON);
    end
  end

  // Next-state logic; a dead gap is abandoned as soon as the demand reverts.
  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    if (!en) begin
      state_d = ST_OFF;
      dt_d    = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_LO_ON;
        end
        ST_LO_ON: begin
          if (raw) begin
            if (dead_time == '0) begin
              state_d = ST_HI_ON;
            end else begin
              state_d = ST_DT_TO_HI;
              dt_d    = dead_time;
            end
          end
        end
        ST_DT_TO_HI: begin
          if (!raw) begin
            state_d = ST_LO_ON;
            dt_d    = '0;
          end else if (dt_q <= DT_W'(1)) begin
            state_d = ST_HI_ON;
            dt_d    = '0;
          end else begin
            dt_d = dt_q - DT_W'(1);
          end
        end
        ST_HI_ON: begin
          if (!raw) begin
            if (dead_time == '0) begin
              state_d = ST_LO_ON;
            end else begin
              state_d = ST_DT_TO_LO;
              dt_d    = dead_time;
            end
          end
        end
        ST_DT_TO_LO: begin
          if (raw) begin
            state_d = ST_HI_ON;
            dt_d    = '0;
          end else if (dt_q <= DT_W'(1)) begin
            state_d = ST_LO_ON;
            dt_d    = '0;
          end else begin
            dt_d = dt_q - DT_W'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          dt_d    = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pid_pwm_driver.sv
// PWM output stage for pid_controller: clamps the control word, double-buffers
// the duty at period boundaries and drives a dead-time protected gate pair.
module pid_pwm_driver
  import pid_pkg::*;
#(
  parameter int unsigned IN_W    = IN_W_DEF,
  parameter int unsigned PWM_W   = PWM_W_DEF,
  parameter int unsigned PRESC_W = PRESC_W_DEF,
  parameter int unsigned DT_W    = DT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [IN_W-1:0]    ctrl_in,
  input  logic               ctrl_valid,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [DT_W-1:0]    dead_time,
  output logic               pwm_hi,
  output logic               pwm_lo,
  output logic               period_start,
  output logic [PWM_W-1:0]   duty_q,
  output logic               sat_hi,
  output logic               sat_lo
);

  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic               en_q;
  logic [PRESC_W-1:0] presc_cnt;
  logic [PWM_W-1:0]   cnt;
  logic [PWM_W-1:0]   pend_duty;
  logic               pend_hi;
  logic               pend_lo;

  logic [PWM_W-1:0]   clamp_duty_c;
  logic               clamp_hi_c;
  logic               clamp_lo_c;
  logic               tick_c;
  logic               boundary_c;
  logic               raw_c;

  // Saturating conversion of the signed control word to an unsigned duty.
  always_comb begin
    clamp_duty_c = ctrl_in[PWM_W-1:0];
    clamp_hi_c   = 1'b0;
    clamp_lo_c   = 1'b0;
    if (ctrl_in[IN_W-1]) begin
      clamp_duty_c = '0;
      clamp_lo_c   = 1'b1;
    end else if (|ctrl_in[IN_W-2:PWM_W]) begin
      clamp_duty_c = CNT_MAX;
      clamp_hi_c   = 1'b1;
    end
  end

  // Re-enabling starts a fresh period so a new duty never applies mid-pulse.
  always_comb begin
    tick_c     = en && (presc_cnt == prescale);
    boundary_c = (en && !en_q) || (tick_c && (cnt == CNT_MAX));
    raw_c      = en && (cnt < duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q         <= 1'b0;
      presc_cnt    <= '0;
      cnt          <= '0;
      pend_duty    <= '0;
      pend_hi      <= 1'b0;
      pend_lo      <= 1'b0;
      duty_q       <= '0;
      sat_hi       <= 1'b0;
      sat_lo       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      en_q <= en;

      if (!en) begin
        presc_cnt <= '0;
        cnt       <= '0;
      end else if (tick_c) begin
        presc_cnt <= '0;
        cnt       <= cnt + PWM_W'(1);
      end else begin
        presc_cnt <= presc_cnt + PRESC_W'(1);
      end

      // Pending captures regardless of en; a word arriving on a boundary waits a period.
      if (ctrl_valid) begin
        pend_duty <= clamp_duty_c;
        pend_hi   <= clamp_hi_c;
        pend_lo   <= clamp_lo_c;
      end

      period_start <= boundary_c;
      if (boundary_c) begin
        duty_q <= pend_duty;
        sat_hi <= pend_hi;
        sat_lo <= pend_lo;
      end
    end
  end

  pwm_deadtime_gen #(
    .DT_W (DT_W)
  ) u_deadtime (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .raw       (raw_c),
    .dead_time (dead_time),
    .pwm_hi    (pwm_hi),
    .pwm_lo    (pwm_lo)
  );

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Self-checking bench for pid_pwm_driver: vector table, directed corner
// sequences and randomized settings against a per-period reference model.
module tb_pid_pwm_driver;

  localparam int unsigned IN_W    = 16;
  localparam int unsigned PWM_W   = 8;
  localparam int unsigned PRESC_W = 8;
  localparam int unsigned DT_W    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [IN_W-1:0]    ctrl_in;
  logic               ctrl_valid;
  logic [PRESC_W-1:0] prescale;
  logic [DT_W-1:0]    dead_time;
  logic               pwm_hi;
  logic               pwm_lo;
  logic               period_start;
  logic [PWM_W-1:0]   duty_q;
  logic               sat_hi;
  logic               sat_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pid_pwm_driver #(
    .IN_W    (IN_W),
    .PWM_W   (PWM_W),
    .PRESC_W (PRESC_W),
    .DT_W    (DT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ctrl_in      (ctrl_in),
    .ctrl_valid   (ctrl_valid),
    .prescale     (prescale),
    .dead_time    (dead_time),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo),
    .period_start (period_start),
    .duty_q       (duty_q),
    .sat_hi       (sat_hi),
    .sat_lo       (sat_lo)
  );

  // The two gate drives must never conduct together.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(pwm_hi && pwm_lo))
      else begin
        errors++;
        $display("FAIL overlap: pwm_hi=%0b pwm_lo=%0b at %0t, required never both 1", pwm_hi, pwm_lo, $time);
      end
    end
  end

  typedef struct {
    int ctrl;
    int dead;
    int presc;
    int duty;
    int shi;
    int slo;
    int hi;
    int lo;
    int len;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_start(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no period_start within 3000 cycles", name);
    end
  endtask

  task automatic load(input int ctrl);
    ctrl_in    = ctrl[IN_W-1:0];
    ctrl_valid = 1'b1;
    @(negedge clk);
    ctrl_valid = 1'b0;
  endtask

  // Steady-state expectations for one full period, derived from duty, dead time and prescale.
  function automatic void model(input int ctrl, input int dead, input int presc,
                                output int duty, output int shi, output int slo,
                                output int hi, output int lo, output int len);
    int h;
    int l;
    shi = 0;
    slo = 0;
    if (ctrl < 0) begin
      duty = 0;
      slo  = 1;
    end else if (ctrl > 255) begin
      duty = 255;
      shi  = 1;
    end else begin
      duty = ctrl;
    end
    len = 256 * (presc + 1);
    h   = duty * (presc + 1);
    l   = len - h;
    if (h <= dead) begin
      hi = 0;
      lo = l;
    end else if (l <= dead) begin
      hi = h;
      lo = 0;
    end else begin
      hi = h - dead;
      lo = l - dead;
    end
  endfunction

  task automatic measure(input string name, input vec_t v);
    bit ok;
    int hi_n;
    int lo_n;
    int len;
    dead_time = v.dead[DT_W-1:0];
    prescale  = v.presc[PRESC_W-1:0];
    load(v.ctrl);
    wait_start(name, ok);
    if (!ok) return;
    wait_start(name, ok);
    if (!ok) return;
    check({name, " duty_q"}, duty_q, v.duty);
    check({name, " sat_hi"}, sat_hi, v.shi);
    check({name, " sat_lo"}, sat_lo, v.slo);
    hi_n = 0;
    lo_n = 0;
    len  = 0;
    do begin
      if (pwm_hi) hi_n++;
      if (pwm_lo) lo_n++;
      len++;
      @(negedge clk);
    end while (!period_start && len < 3000);
    check({name, " period"}, len, v.len);
    check({name, " hi cycles"}, hi_n, v.hi);
    check({name, " lo cycles"}, lo_n, v.lo);
  endtask

  vec_t vecs[8];

  initial begin
    bit ok;
    vec_t rv;

    vecs[0] = '{ctrl: 64,  dead: 0, presc: 0, duty: 64,  shi: 0, slo: 0, hi: 64,  lo: 192, len: 256};
    vecs[1] = '{ctrl: -5,  dead: 0, presc: 0, duty: 0,   shi: 0, slo: 1, hi: 0,   lo: 256, len: 256};
    vecs[2] = '{ctrl: 300, dead: 0, presc: 0, duty: 255, shi: 1, slo: 0, hi: 255, lo: 1,   len: 256};
    vecs[3] = '{ctrl: 64,  dead: 3, presc: 0, duty: 64,  shi: 0, slo: 0, hi: 61,  lo: 189, len: 256};
    vecs[4] = '{ctrl: 64,  dead: 3, presc: 3, duty: 64,  shi: 0, slo: 0, hi: 253, lo: 765, len: 1024};
    vecs[5] = '{ctrl: 255, dead: 3, presc: 0, duty: 255, shi: 0, slo: 0, hi: 255, lo: 0,   len: 256};
    vecs[6] = '{ctrl: 2,   dead: 3, presc: 0, duty: 2,   shi: 0, slo: 0, hi: 0,   lo: 254, len: 256};
    vecs[7] = '{ctrl: 0,   dead: 0, presc: 0, duty: 0,   shi: 0, slo: 0, hi: 0,   lo: 256, len: 256};

    rst        = 1'b1;
    en         = 1'b0;
    ctrl_in    = '0;
    ctrl_valid = 1'b0;
    prescale   = '0;
    dead_time  = '0;
    step(3);
    check("reset pwm_hi", pwm_hi, 0);
    check("reset pwm_lo", pwm_lo, 0);
    check("reset period_start", period_start, 0);
    check("reset duty_q", duty_q, 0);
    check("reset sat_hi", sat_hi, 0);
    check("reset sat_lo", sat_lo, 0);

    rst = 1'b0;
    en  = 1'b1;
    step(1);
    check("first en period_start", period_start, 1);

    for (int i = 0; i < 8; i++) measure($sformatf("vec%0d", i), vecs[i]);

    // Mid-period update must wait for the next boundary.
    dead_time = '0;
    prescale  = '0;
    load(64);
    wait_start("midchg", ok);
    wait_start("midchg", ok);
    step(100);
    load(128);
    step(50);
    check("midchg duty held", duty_q, 64);
    wait_start("midchg", ok);
    check("midchg duty applied", duty_q, 128);

    // Word coincident with a boundary applies one period later.
    step(255);
    ctrl_in    = 16'd32;
    ctrl_valid = 1'b1;
    step(1);
    ctrl_valid = 1'b0;
    check("coinc period_start", period_start, 1);
    check("coinc duty old", duty_q, 128);
    wait_start("coinc", ok);
    check("coinc duty new", duty_q, 32);

    // Drop en while the high side conducts, then reset mid-period.
    step(10);
    check("endrop pwm_hi before", pwm_hi, 1);
    en = 1'b0;
    step(1);
    check("endrop pwm_hi", pwm_hi, 0);
    check("endrop pwm_lo", pwm_lo, 0);
    step(5);
    check("endrop held pwm_lo", pwm_lo, 0);
    check("endrop no period_start", period_start, 0);
    en = 1'b1;
    step(1);
    check("reen period_start", period_start, 1);
    check("reen duty_q", duty_q, 32);
    step(50);
    rst = 1'b1;
    step(1);
    check("midrst pwm_hi", pwm_hi, 0);
    check("midrst pwm_lo", pwm_lo, 0);
    check("midrst duty_q", duty_q, 0);
    rst = 1'b0;
    step(1);
    check("rstrel period_start", period_start, 1);
    check("rstrel duty_q", duty_q, 0);
    step(20);
    check("rstrel pwm_lo", pwm_lo, 1);
    check("rstrel pwm_hi", pwm_hi, 0);

    // Randomized settings against the reference model.
    for (int t = 0; t < 12; t++) begin
      rv.ctrl  = int'($urandom_range(700, 0)) - 200;
      rv.dead  = int'($urandom_range(15, 0));
      rv.presc = int'($urandom_range(2, 0));
      model(rv.ctrl, rv.dead, rv.presc, rv.duty, rv.shi, rv.slo, rv.hi, rv.lo, rv.len);
      measure($sformatf("rand%0d(c=%0d d=%0d p=%0d)", t, rv.ctrl, rv.dead, rv.presc), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
